// File: rtl/rr_reg_arbiter.sv
// ---------------------------------------------------------------------------
// rr_reg_arbiter
//   Arbitrates one shared WIDTH-bit storage register among four requesters
//   using a round-robin pointer. A winner may keep the register (LOCKED) for
//   as long as it holds both req and lock; each held cycle reloads its data.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous reset, active-high
//   req      : per-requester write request (bit i = requester i)
//   lock     : per-requester hold request, only meaningful together with req
//   d_in     : packed data, requester i drives d_in[i*WIDTH +: WIDTH]
//   gnt      : registered one-hot grant, all-zero when nothing was captured
//   owner    : registered index of the last granted requester
//   q        : shared storage register
//   q_valid  : high in every cycle after an edge that loaded q
// ---------------------------------------------------------------------------
module rr_reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         lock,
  input  logic [4*WIDTH-1:0] d_in,
  output logic [3:0]         gnt,
  output logic [1:0]         owner,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             hold;

  // Round-robin search: walk the order backwards so the candidate closest
  // to ptr_q is the last one written and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  // The current owner keeps the register only while it asks for it and
  // keeps lock asserted; any other lock bits are ignored.
  assign hold = (state_q == LOCKED) && req[owner_q] && lock[owner_q];

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    data_d  = data_q;
    valid_d = 1'b0;

    if (hold) begin
      data_d  = d_in[owner_q*WIDTH +: WIDTH];
      gnt_d   = 4'b0001 << owner_q;
      valid_d = 1'b1;
    end else if (win_found) begin
      // Releasing owner falls to lowest priority because ptr_q = owner+1.
      data_d  = d_in[win_idx*WIDTH +: WIDTH];
      gnt_d   = 4'b0001 << win_idx;
      owner_d = win_idx;
      ptr_d   = win_idx + 2'd1;
      valid_d = 1'b1;
      state_d = lock[win_idx] ? LOCKED : GRANT;
    end else begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = data_q;
  assign q_valid = valid_q;

endmodule
